keypad_scanner: RTL and testbench

//  Scans the car-panel 4x4 key matrix, debounces it and emits one (buttonBus, pressed) event per key press.
//  It is the transmitting end of the button interface consumed by centralFSM.

---
 rtl/elevator_pkg.sv | 65 ++++++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the car-panel button interface: the key codes that
//   keypad_scanner transmits and centralFSM decodes, the scanner state type,
//   the matrix keymap and two small helpers for active-low row/column patterns.
package elevator_pkg;

    localparam logic [3:0] KEY_STOP   = 4'hA;
    localparam logic [3:0] KEY_RESUME = 4'hB;
    localparam logic [3:0] KEY_UP     = 4'hC;
    localparam logic [3:0] KEY_DOWN   = 4'hD;
    localparam logic [3:0] KEY_ESCAPE = 4'hE;
    localparam logic [3:0] KEY_ENTER  = 4'hF;

    typedef enum logic [2:0] {
        KP_SCAN,
        KP_DEBOUNCE,
        KP_EMIT,
        KP_HOLD,
        KP_RELEASE
    } kp_state_t;

    // Panel layout, rows top to bottom, columns left to right:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_STOP;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_RESUME;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_UP;
            4'hC: code = KEY_ESCAPE;
            4'hD: code = 4'h0;
            4'hE: code = KEY_ENTER;
            default: code = KEY_DOWN;
        endcase
        return code;
    endfunction

    // True when exactly one bit of an active-low pattern is low.
    function automatic logic single_low(input logic [3:0] bits_n);
        logic [3:0] act;
        act = ~bits_n;
        return (act != 4'h0) && ((act & (act - 4'd1)) == 4'h0);
    endfunction

    // Position of the low bit in an active-low one-hot pattern.
    function automatic logic [1:0] low_index(input logic [3:0] bits_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!bits_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
//   Two-flop synchroniser for the asynchronous, active-low matrix rows.
//   Resets to 4'hF so that no key appears pressed coming out of reset.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   async_bits  raw row levels from the pins
//   sync_bits   row levels in the clk domain, two cycles late
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] async_bits,
    output logic [3:0] sync_bits
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 4'hF;
            sync_bits <= 4'hF;
        end else begin
            meta      <= async_bits;
            sync_bits <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans the 4x4 car-panel key matrix, debounces presses and releases, and
//   emits one (buttonBus, pressed) event per key press toward centralFSM.
//   buttonBus is non-zero only while pressed is high.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   row_n      matrix rows, active-low, asynchronous
//   col_drv_n  column drive, one-hot active-low (exactly one bit low)
//   buttonBus  key code of the accepted press, 0 when idle
//   pressed    PRESS_CYCLES-wide pulse per accepted press
// Build option:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held UP or DOWN key re-emits after
//                         REPEAT_DELAY cycles and then every REPEAT_PERIOD
//                         cycles until released.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// KP_SCAN     | rotate columns, look for a single low row at end of each slot
// KP_DEBOUNCE | column frozen, count cycles the captured row pattern stays put
// KP_EMIT     | drive pressed/buttonBus for PRESS_CYCLES cycles
// KP_HOLD     | key accepted, wait for all rows high
// KP_RELEASE  | count cycles with all rows high before scanning again
module keypad_scanner #(
    parameter int SCAN_DIV      = 16,
    parameter int DEBOUNCE_CNT  = 1000,
    parameter int PRESS_CYCLES  = 2,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_drv_n,
    output logic [3:0] buttonBus,
    output logic       pressed
);

    import elevator_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int PLS_W = $clog2(PRESS_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [PLS_W-1:0] PLS_DONE = PLS_W'(PRESS_CYCLES);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             repeating;
`endif

    kp_state_t        state;
    logic [3:0]       rs;
    logic [3:0]       cap_rows;
    logic [3:0]       key_code;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [PLS_W-1:0] pls_cnt;
    logic [3:0]       col_next;

    keypad_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_bits (row_n),
        .sync_bits  (rs)
    );

    // The low bit walks upward: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    assign col_next = {col_drv_n[2:0], col_drv_n[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= KP_SCAN;
            col_drv_n <= 4'b1110;
            buttonBus <= 4'h0;
            pressed   <= 1'b0;
            cap_rows  <= 4'hF;
            key_code  <= 4'h0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            pls_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            case (state)
                KP_SCAN: begin
                    // rs lags the column drive by two cycles, so the pattern is
                    // only trusted in the last cycle of each column slot.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (single_low(rs)) begin
                            cap_rows <= rs;
                            key_code <= keymap(low_index(rs), low_index(col_drv_n));
                            deb_cnt  <= '0;
                            state    <= KP_DEBOUNCE;
                        end else begin
                            col_drv_n <= col_next;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                KP_DEBOUNCE: begin
                    if (rs != cap_rows) begin
                        deb_cnt <= '0;
                        div_cnt <= '0;
                        state   <= KP_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        pls_cnt <= '0;
                        state   <= KP_EMIT;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                KP_EMIT: begin
                    if (pls_cnt == PLS_DONE) begin
                        pressed   <= 1'b0;
                        buttonBus <= 4'h0;
                        pls_cnt   <= '0;
                        state     <= KP_HOLD;
                    end else begin
                        pressed   <= 1'b1;
                        buttonBus <= key_code;
                        pls_cnt   <= pls_cnt + 1'b1;
                    end
                end

                KP_HOLD: begin
                    if (rs == 4'hF) begin
                        deb_cnt <= '0;
                        state   <= KP_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (key_code == KEY_UP || key_code == KEY_DOWN) begin
                        if (rep_cnt == (repeating ? REP_NEXT : REP_FIRST)) begin
                            rep_cnt   <= '0;
                            repeating <= 1'b1;
                            pls_cnt   <= '0;
                            state     <= KP_EMIT;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
`endif
                end

                KP_RELEASE: begin
                    // A low row here is release bounce: go back to waiting,
                    // never back to emitting.
                    if (rs != 4'hF) begin
                        deb_cnt <= '0;
                        state   <= KP_HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt   <= '0;
                        div_cnt   <= '0;
                        col_drv_n <= col_next;
                        state     <= KP_SCAN;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt   <= '0;
                        repeating <= 1'b0;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= KP_SCAN;
                    col_drv_n <= 4'b1110;
                    buttonBus <= 4'h0;
                    pressed   <= 1'b0;
                    div_cnt   <= '0;
                    deb_cnt   <= '0;
                    pls_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int PRESS_CYCLES = 2;
    localparam int REP_DELAY    = 60;
    localparam int REP_PERIOD   = 30;
    localparam int PULSE_WAIT   = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_drv_n;
    logic [3:0] buttonBus;
    logic       pressed;

    logic [15:0] closed = 16'h0000;
    logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0]  exp_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .PRESS_CYCLES  (PRESS_CYCLES),
        .REPEAT_DELAY  (REP_DELAY),
        .REPEAT_PERIOD (REP_PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_drv_n (col_drv_n),
        .buttonBus (buttonBus),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed switch at (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (closed[r*4+c] && (col_drv_n[c] === 1'b0)) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rising pressed pops one expected code.
    task automatic run_monitor();
        int         plen;
        logic [3:0] cur;
        plen = 0;
        cur  = 4'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                plen = 0;
            end else if (pressed) begin
                if (plen == 0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got code %h expected no event at %0t", buttonBus, $time);
                        cur = buttonBus;
                    end else begin
                        cur = exp_q.pop_front();
                        check4("event_code", buttonBus, cur);
                    end
                end else begin
                    check4("code_stable", buttonBus, cur);
                end
                plen++;
            end else begin
                if (plen != 0) check_int("pulse_width", plen, PRESS_CYCLES);
                plen = 0;
                check4("idle_bus", buttonBus, 4'h0);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name);
        int t;
        t = 0;
        while (!pressed && t < PULSE_WAIT) begin
            tick(1);
            t++;
        end
        n_cmp++;
        if (!pressed) begin
            n_fail++;
            $display("FAIL %s_timeout: got no pulse expected one within %0d cycles", name, PULSE_WAIT);
        end
    endtask

    task automatic press_clean(input int r, input int c, input int hold_after);
        closed[r*4+c] = 1'b1;
        exp_q.push_back(kmap[r*4+c]);
        wait_pulse("press");
        tick(hold_after);
        closed = 16'h0000;
        tick(40);
    endtask

    initial begin
        logic [3:0] exp_col;
        int         r;
        int         c;

        fork
            run_monitor();
        join_none

        // Reset and column rotation
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check4("reset_col", col_drv_n, 4'b1110);
        check4("reset_pressed", {3'b000, pressed}, 4'h0);
        check4("reset_bus", buttonBus, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check4("col_rotate", col_drv_n, exp_col);
        end

        // Clean press of (1,1)
        press_clean(1, 1, 40);

        // (3,3) with 2-cycle bounces, then stable
        for (int i = 0; i < 3; i++) begin
            closed[15] = 1'b1;
            tick(2);
            closed[15] = 1'b0;
            tick($urandom_range(2, 6));
        end
        press_clean(3, 3, 40);

        // Ghosting: (0,0) and (2,0) together give nothing; dropping (2,0) gives '1'
        closed[0] = 1'b1;
        closed[8] = 1'b1;
        tick(100);
        closed[8] = 1'b0;
        exp_q.push_back(kmap[0]);
        wait_pulse("ghost_release");
        tick(40);
        closed = 16'h0000;
        tick(40);

        // Release bounce on (3,2): one event, then a clean re-press gives another
        closed[14] = 1'b1;
        exp_q.push_back(kmap[14]);
        wait_pulse("bounce_key");
        tick(20);
        for (int i = 0; i < 3; i++) begin
            closed[14] = 1'b0;
            tick($urandom_range(1, 4));
            closed[14] = 1'b1;
            tick($urandom_range(1, 4));
        end
        closed = 16'h0000;
        tick(40);
        press_clean(3, 2, 20);

        // Random single presses
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            tick($urandom_range(0, 20));
            press_clean(r, c, $urandom_range(5, 40));
        end

        // Reset on the first cycle of pressed truncates the pulse for good
        closed[6] = 1'b1;
        wait_pulse("pre_reset");
        rst    = 1'b1;
        closed = 16'h0000;
        tick(1);
        check4("mid_reset_pressed", {3'b000, pressed}, 4'h0);
        check4("mid_reset_bus", buttonBus, 4'h0);
        check4("mid_reset_col", col_drv_n, 4'b1110);
        rst = 1'b0;
        tick(60);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Held UP: first event plus three repeats inside a 150-cycle hold
        closed[11] = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(kmap[11]);
        wait_pulse("repeat_first");
        tick(150);
        closed = 16'h0000;
        tick(40);
`else
        // Held UP without repeat: exactly one event
        closed[11] = 1'b1;
        exp_q.push_back(kmap[11]);
        wait_pulse("up_single");
        tick(150);
        closed = 16'h0000;
        tick(40);
`endif

        tick(30);
        check_int("events_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
